// File: rtl/fp_div_if.sv
// ---------------------------------------------------------------------------
// fp_div_if -- start/done handshake bundle for the sequential FP divider.
//
//   start        requester -> divider  request, sampled only while idle
//   a, b         requester -> divider  dividend / divisor, IEEE-754 single
//   busy         divider -> requester  high while an operation is in flight
//   done         divider -> requester  one-cycle pulse, result valid
//   result       divider -> requester  quotient, held until next accepted start
//   div_by_zero  divider -> requester  finite nonzero / zero flag, held with result
//
// Modports: master = requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface fp_div_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, div_by_zero
    );
endinterface : fp_div_if

// File: rtl/fp_div_seq.sv
// ---------------------------------------------------------------------------
// fp_div_seq -- iterative IEEE-754 single-precision divider.
//
// One quotient bit per clock from a restoring shift-subtract loop. Operands
// with a zero exponent are treated as zero (denormals flushed); the quotient
// is truncated and out-of-range exponents saturate to signed inf / zero.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; abandons any operation in flight
//   bus    fp_div_if.slave: start, a, b in; busy, done, result,
//          div_by_zero out
//
// Flow: IDLE -> SPECIAL -> IDLE           (NaN / inf / zero operands)
//       IDLE -> DIV (25 cycles) -> NORM -> IDLE
// ---------------------------------------------------------------------------
module fp_div_seq #(
    parameter int BIAS  = 127,
    parameter int QBITS = 25
) (
    input  logic     clk,
    input  logic     rst_n,
    fp_div_if.slave  bus
);
    localparam int          QTOP = QBITS - 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SPECIAL = 2'd1,
        S_DIV     = 2'd2,
        S_NORM    = 2'd3
    } state_t;

    // Outcome of operand classification, decided once at accept time.
    typedef struct packed {
        logic        special;
        logic        dbz;
        logic [31:0] word;
    } spec_t;

    function automatic spec_t classify(input logic [31:0] x, input logic [31:0] y);
        spec_t r;
        logic  x_zero, x_inf, x_nan, y_zero, y_inf, y_nan, s;
        x_zero = (x[30:23] == 8'h00);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_zero = (y[30:23] == 8'h00);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        s      = x[31] ^ y[31];
        r      = '0;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            r.special = 1'b1;
            r.word    = QNAN;
        end else if (x_inf) begin
            r.special = 1'b1;
            r.word    = {s, 8'hFF, 23'd0};
        end else if (y_zero) begin
            // x is finite and nonzero here: the only divide-by-zero case.
            r.special = 1'b1;
            r.dbz     = 1'b1;
            r.word    = {s, 8'hFF, 23'd0};
        end else if (x_zero || y_inf) begin
            r.special = 1'b1;
            r.word    = {s, 31'd0};
        end
        return r;
    endfunction

    state_t             state_q,  state_d;
    logic [31:0]        spec_word_q, spec_word_d;
    logic               spec_dbz_q,  spec_dbz_d;
    logic               sign_q,   sign_d;
    logic signed [9:0]  exp_q,    exp_d;
    logic [25:0]        rem_q,    rem_d;
    logic [23:0]        div_q,    div_d;
    logic [QTOP:0]      q_q,      q_d;
    logic [4:0]         cnt_q,    cnt_d;
    logic [31:0]        result_q, result_d;
    logic               dbz_q,    dbz_d;
    logic               done_q,   done_d;

    spec_t              acc_spec;
    logic               ge;
    logic [25:0]        rem_sub;
    logic signed [9:0]  exp_n;
    logic [22:0]        frac;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, exactly like real registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            spec_word_q <= '0;
            spec_dbz_q  <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            spec_word_q <= spec_word_d;
            spec_dbz_q  <= spec_dbz_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        spec_word_d = spec_word_q;
        spec_dbz_d  = spec_dbz_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        rem_d       = rem_q;
        div_d       = div_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        acc_spec = classify(bus.a, bus.b);

        // One restoring step: subtract when the partial remainder covers d.
        ge      = (rem_q >= {2'b00, div_q});
        rem_sub = ge ? (rem_q - {2'b00, div_q}) : rem_q;

        // Quotient lies in (0.5, 2): a clear integer bit means one more
        // left shift of the fraction and one less on the exponent.
        exp_n = q_q[QTOP] ? exp_q : (exp_q - 10'sd1);
        frac  = q_q[QTOP] ? q_q[QTOP-1:1] : q_q[QTOP-2:0];

        case (state_q)
            S_IDLE: begin
                // The done cycle is already IDLE; a start there is ignored.
                if (bus.start && !done_q) begin
                    spec_word_d = acc_spec.word;
                    spec_dbz_d  = acc_spec.dbz;
                    sign_d      = bus.a[31] ^ bus.b[31];
                    exp_d       = $signed({2'b00, bus.a[30:23]} - {2'b00, bus.b[30:23]}
                                          + 10'(BIAS));
                    rem_d       = {2'b00, 1'b1, bus.a[22:0]};
                    div_d       = {1'b1, bus.b[22:0]};
                    q_d         = '0;
                    cnt_d       = '0;
                    dbz_d       = 1'b0;
                    state_d     = acc_spec.special ? S_SPECIAL : S_DIV;
                end
            end
            S_SPECIAL: begin
                result_d = spec_word_q;
                dbz_d    = spec_dbz_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            S_DIV: begin
                q_d   = {q_q[QTOP-1:0], ge};
                rem_d = rem_sub << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(QTOP)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (exp_n >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                end else if (exp_n <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                end else begin
                    result_d = {sign_q, exp_n[7:0], frac};
                end
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule : fp_div_seq

// File: tb/tb_fp_div_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_div_seq -- self-checking bench for fp_div_seq.
//
// Directed vectors plus randomized operands compared against an arithmetic
// reference model (integer quotient of the significands, truncated).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fp_div_seq;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    fp_div_if bus ();

    fp_div_seq #(.BIAS(127), .QBITS(25)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: classify operands, else floor(ma * 2^24 / mb) then scale.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic z, output bit sp);
        int          ex, ey, e;
        bit          xz, xi, xn, yz, yi, yn, s;
        longint      q;
        logic [22:0] frac;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        s  = x[31] ^ y[31];
        z  = 1'b0;
        sp = 1'b1;
        if (xn || yn || (xz && yz) || (xi && yi)) r = 32'h7FC00000;
        else if (xi) r = {s, 8'hFF, 23'd0};
        else if (yz) begin r = {s, 8'hFF, 23'd0}; z = 1'b1; end
        else if (xz || yi) r = {s, 31'd0};
        else begin
            sp = 1'b0;
            q  = (longint'({1'b1, x[22:0]}) << 24) / longint'({1'b1, y[22:0]});
            e  = ex - ey + 127;
            if (q >= (longint'(1) << 24)) frac = 23'(q >> 1);
            else begin frac = 23'(q); e = e - 1; end
            if (e >= 255)     r = {s, 8'hFF, 23'd0};
            else if (e <= 0)  r = {s, 31'd0};
            else              r = {s, 8'(e), frac};
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        int          sel;
        logic [7:0]  e;
        logic [31:0] m;
        sel = $urandom_range(0, 15);
        m   = $urandom;
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else if (sel < 9)  e = 8'($urandom_range(100, 154));
        else               e = 8'($urandom_range(1, 254));
        if (sel == 2) begin m = '0; e = 8'hFF; end
        return {1'($urandom_range(0, 1)), e, m[22:0]};
    endfunction

    // Issue one operation and observe 32 cycles. Cycle i is the sample after
    // the i-th rising edge, edge 1 being the one that samples start.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int poke,
                         input logic [31:0] px, input logic [31:0] py,
                         output logic [31:0] res, output logic dbz, output int lat,
                         output int busy_n, output int done_n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        res = '0; dbz = 1'b0; lat = 0; busy_n = 0; done_n = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (poke != 0 && i == poke) begin
                bus.start = 1'b1;
                bus.a     = px;
                bus.b     = py;
            end
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) begin
                done_n++;
                if (lat == 0) begin
                    lat = i;
                    res = bus.result;
                    dbz = bus.div_by_zero;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        #12;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=00000000", bus.result); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        logic [31:0] va [3] = '{32'h40C00000, 32'h3F800000, 32'hBFC00000};
        logic [31:0] vb [3] = '{32'h40000000, 32'h40400000, 32'h3F000000};
        logic [31:0] vr [3] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000};
        logic [31:0] res; logic dbz; int lat, bn, dn;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], 0, '0, '0, res, dbz, lat, bn, dn);
            checks++; if (res !== vr[i]) begin errors++; $display("FAIL normal_result[%0d] got=%h want=%h", i, res, vr[i]); end
            checks++; if (lat != 27) begin errors++; $display("FAIL normal_latency[%0d] got=%0d want=27", i, lat); end
            checks++; if (bn != 26) begin errors++; $display("FAIL normal_busy[%0d] got=%0d want=26", i, bn); end
            checks++; if (dn != 1 || dbz !== 1'b0) begin errors++; $display("FAIL normal_done_dbz[%0d] got=%0d/%b want=1/0", i, dn, dbz); end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [3] = '{32'h3F800000, 32'h00000000, 32'h7F800000};
        logic [31:0] vb [3] = '{32'h00000000, 32'h00000000, 32'hC0000000};
        logic [31:0] vr [3] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000};
        logic        vz [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] res; logic dbz; int lat, bn, dn;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], 0, '0, '0, res, dbz, lat, bn, dn);
            checks++; if (res !== vr[i]) begin errors++; $display("FAIL special_result[%0d] got=%h want=%h", i, res, vr[i]); end
            checks++; if (dbz !== vz[i]) begin errors++; $display("FAIL special_dbz[%0d] got=%b want=%b", i, dbz, vz[i]); end
            checks++; if (lat != 2 || bn != 1) begin errors++; $display("FAIL special_timing[%0d] lat=%0d busy=%0d want=2/1", i, lat, bn); end
        end
    endtask

    task automatic test_range();
        logic [31:0] va [2] = '{32'h7F000000, 32'h00800000};
        logic [31:0] vb [2] = '{32'h3F000000, 32'h40000000};
        logic [31:0] vr [2] = '{32'h7F800000, 32'h00000000};
        logic [31:0] res; logic dbz; int lat, bn, dn;
        for (int i = 0; i < 2; i++) begin
            do_op(va[i], vb[i], 0, '0, '0, res, dbz, lat, bn, dn);
            checks++; if (res !== vr[i] || lat != 27) begin errors++; $display("FAIL range[%0d] got=%h lat=%0d want=%h lat=27", i, res, lat, vr[i]); end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] res; logic dbz; int lat, bn, dn;
        do_op(32'h40C00000, 32'h40000000, 10, 32'h3F800000, 32'h40400000, res, dbz, lat, bn, dn);
        checks++; if (res !== 32'h40400000) begin errors++; $display("FAIL ignore_result got=%h want=40400000", res); end
        checks++; if (dn != 1 || lat != 27) begin errors++; $display("FAIL ignore_done got=%0d pulses lat=%0d want=1 lat=27", dn, lat); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [31:0] r1, r2;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h40C00000; bus.b = 32'h40000000;
        lat1 = 0; r1 = '0;
        for (int i = 1; i <= 40 && lat1 == 0; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin lat1 = i; r1 = bus.result; end
        end
        checks++; if (r1 !== 32'h40400000 || lat1 != 27) begin errors++; $display("FAIL b2b_first got=%h lat=%0d want=40400000 lat=27", r1, lat1); end
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h40400000;
        lat2 = 0; r2 = '0;
        for (int i = 1; i <= 40 && lat2 == 0; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin lat2 = i; r2 = bus.result; end
        end
        checks++; if (r2 !== 32'h3EAAAAAA || lat2 != 27) begin errors++; $display("FAIL b2b_second got=%h lat=%0d want=3eaaaaaa lat=27", r2, lat2); end
    endtask

    task automatic test_reset_mid();
        int seen;
        logic [31:0] res; logic dbz; int lat, bn, dn;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h40C00000; bus.b = 32'h40000000;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL midrst_result got=%h want=00000000", bus.result); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_done got=%0d pulses want=0", seen); end
        do_op(32'h40C00000, 32'h40000000, 0, '0, '0, res, dbz, lat, bn, dn);
        checks++; if (res !== 32'h40400000 || lat != 27) begin errors++; $display("FAIL midrst_recover got=%h lat=%0d want=40400000 lat=27", res, lat); end
    endtask

    task automatic test_random();
        logic [31:0] x, y, res, er;
        logic dbz, ez;
        bit sp;
        int lat, bn, dn;
        for (int n = 0; n < 150; n++) begin
            x = rand_fp();
            y = rand_fp();
            model(x, y, er, ez, sp);
            do_op(x, y, 0, '0, '0, res, dbz, lat, bn, dn);
            checks++; if (res !== er) begin errors++; $display("FAIL rand_result a=%h b=%h got=%h want=%h", x, y, res, er); end
            checks++; if (dbz !== ez) begin errors++; $display("FAIL rand_dbz a=%h b=%h got=%b want=%b", x, y, dbz, ez); end
            checks++; if (lat != (sp ? 2 : 27) || dn != 1) begin errors++; $display("FAIL rand_timing a=%h b=%h lat=%0d pulses=%0d want=%0d/1", x, y, lat, dn, sp ? 2 : 27); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_range();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fp_div_seq

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
Iterative IEEE-754 single-precision divider. It fills the empty DIV opcode slot of the ALU and is the inverse operation of the existing combinational multiplier. It uses a start/done handshake and computes one quotient bit per clock with a restoring shift-subtract loop. It sits beside the ALU, and its output word is in the same format as the ALU output.

Parameters:
BIAS, 127, exponent bias applied when forming the result exponent.
QBITS, 25, quotient bits generated (1 integer bit + 24 fraction bits). Fixed for single precision; other values are unsupported.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
a  in  32  dividend, IEEE-754 single
b  in  32  divisor, IEEE-754 single
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse; result valid
result  out  32  quotient; held until next accepted start
div_by_zero  out  1  set with done when a finite nonzero a is divided by zero; held with result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0x00000000, div_by_zero=0. Applies mid-operation: the in-flight divide is abandoned and no done is produced.
- Accept: in IDLE, start=1 at edge k latches a, b, sets busy=1, clears div_by_zero. start is ignored while busy=1 or in the cycle done=1.
- Input classes: exp=0 is zero (denormals flushed, mantissa ignored); exp=255 with mant=0 is inf; exp=255 with mant!=0 is NaN.
- Special cases resolve in state SPECIAL. done=1 in the cycle after edge k+1.
  - Any NaN, 0/0 or inf/inf gives 0x7FC00000 (sign 0).
  - x/0 with x finite nonzero gives signed inf and div_by_zero=1.
  - inf/x with x finite gives signed inf.
  - 0/x or x/inf gives signed zero.
  - Sign is sa^sb except for NaN.
- Normal path, state DIV: rem (26b) := {1'b0,1,ma}; divisor d := {1,mb}; exp_t (10b signed) := ea - eb + BIAS.
  - Each of 25 cycles (edges k+1..k+25): if rem >= d then q bit=1 and rem -= d, else q bit=0; rem <<= 1. Bits fill q[24] down to q[0].
  - Iteration counter counts 0..24; leaving DIV at count 24.
- State NORM (edge k+26):
  - If q[24]=1: frac=q[23:1], exp=exp_t.
  - Else: frac=q[22:0], exp=exp_t-1.
  - Rounding is truncation, with no sticky or round bits. This matches the ALU's multiplier.
  - exp >= 255 gives signed inf. exp <= 0 gives signed zero (no denormal output).
- done=1 for exactly one cycle after edge k+26 (normal) or k+1 (special). busy falls in the same cycle done rises. FSM returns to IDLE; a start in the cycle after done is accepted.
- State encoding: IDLE, SPECIAL, DIV, NORM. Any unused encoding returns to IDLE.
- result and div_by_zero change only on NORM/SPECIAL completion or reset.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000, done exactly 27 cycles after accept edge, busy high 26 cycles, div_by_zero=0.
- 0x3F800000 / 0x40400000 (1.0/3.0) -> 0x3EAAAAAA (truncated, not 0x3EAAAAAB); then 0xBFC00000 / 0x3F000000 (-1.5/0.5) -> 0xC0400000.
- Specials, each done 2 cycles after accept:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1.
  - 0x00000000 / 0x00000000 -> 0x7FC00000, div_by_zero=0.
  - 0x7F800000 / 0xC0000000 -> 0xFF800000.
- Range: 0x7F000000 / 0x3F000000 -> 0x7F800000 (overflow); 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush).
- Pulse start with new operands at cycle 10 of a divide -> ignored; first result unchanged, only one done pulse.
- Back-to-back: start asserted in the cycle after done -> accepted, second result correct.
- Deassert rst_n at cycle 12 of a divide -> busy=0, result=0, no done. After release, a fresh 6.0/2.0 completes normally.
